// File: rtl/gb_bus_pkg.sv
// gb_bus_pkg
//   Shared bus constants, the OAM DMA state encoding, and the HRAM address
//   decode used by the CPU/DMA bus arbiter.
package gb_bus_pkg;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_BASE     = 16'hFE00;
    localparam logic [15:0] HRAM_LO      = 16'hFF80;
    localparam logic [15:0] HRAM_HI      = 16'hFFFE;
    localparam int          DMA_LENGTH   = 160;

    typedef enum logic [1:0] {
        IDLE,
        DMA_READ,
        DMA_WRITE
    } dma_state_t;

    // True when addr lies in the inclusive HRAM window. The bounds default
    // to the standard map but can be overridden by a parameterised caller.
    function automatic logic is_hram(input logic [15:0] addr,
                                     input logic [15:0] lo = HRAM_LO,
                                     input logic [15:0] hi = HRAM_HI);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter
//   Shares the single-port system memory bus between the CPU and an OAM DMA
//   engine. A CPU write to the DMA register starts a DMA_LENGTH-byte copy
//   from {src_hi, 8'h00} to OAM as alternating read/write bus cycles. While
//   the copy runs the CPU may only reach HRAM (which stalls the DMA for that
//   cycle); other CPU reads return 8'hFF and other CPU writes are dropped.
//
// Ports
//   clk, reset         : clock, synchronous active-high reset
//   cpu_address        : CPU bus address
//   cpu_data_out       : CPU write data
//   cpu_write_enable   : 1 = CPU write, 0 = CPU read
//   cpu_data_in        : read data returned to the CPU (1-cycle latency)
//   mem_address        : memory address
//   mem_data_out       : memory write data
//   mem_write_enable   : memory write strobe
//   mem_data_in        : registered memory read data
//   dma_active         : registered, high while a transfer is in progress
module oam_dma_arbiter
    import gb_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = gb_bus_pkg::DMA_REG_ADDR,
    parameter int          DMA_LENGTH   = gb_bus_pkg::DMA_LENGTH,
    parameter logic [15:0] OAM_BASE     = gb_bus_pkg::OAM_BASE,
    parameter logic [15:0] HRAM_LO      = gb_bus_pkg::HRAM_LO,
    parameter logic [15:0] HRAM_HI      = gb_bus_pkg::HRAM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic [7:0]  cpu_data_out,
    input  logic        cpu_write_enable,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] mem_address,
    output logic [7:0]  mem_data_out,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_data_in,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

    dma_state_t state_reg, state_next;
    logic [7:0] idx_reg, idx_next;
    logic [7:0] src_hi_reg, src_hi_next;
    logic [7:0] dma_byte_reg;
    logic       blocked_reg, blocked_next;
    // Previous cycle was a granted DMA_READ, so mem_data_in holds the source
    // byte right now (bypass path) and must be captured into dma_byte_reg.
    logic       rd_granted_reg, rd_granted_next;
    logic       dma_active_reg;

    logic       cpu_hram;
    logic [7:0] src_eff;

    assign cpu_hram = is_hram(cpu_address, HRAM_LO, HRAM_HI);
    // Echo RAM sources (E0..FF) alias to C0..DF.
    assign src_eff  = (src_hi_reg >= 8'hE0) ? (src_hi_reg - 8'h20) : src_hi_reg;

    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        src_hi_next      = src_hi_reg;
        rd_granted_next  = 1'b0;
        mem_address      = cpu_address;
        mem_data_out     = cpu_data_out;
        mem_write_enable = cpu_write_enable;

        case (state_reg)
            IDLE: begin
                // The register write still reaches memory so it reads back.
                if (cpu_write_enable && (cpu_address == DMA_REG_ADDR)) begin
                    state_next  = DMA_READ;
                    src_hi_next = cpu_data_out;
                    idx_next    = 8'h00;
                end
            end
            DMA_READ: begin
                if (!cpu_hram) begin
                    mem_address      = {src_eff, idx_reg};
                    mem_write_enable = 1'b0;
                    rd_granted_next  = 1'b1;
                    state_next       = DMA_WRITE;
                end
            end
            DMA_WRITE: begin
                if (!cpu_hram) begin
                    mem_address      = OAM_BASE + {8'h00, idx_reg};
                    mem_write_enable = 1'b1;
                    mem_data_out     = rd_granted_reg ? mem_data_in : dma_byte_reg;
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DMA_READ;
                        idx_next   = idx_reg + 8'h01;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        blocked_next = (state_reg != IDLE) && !cpu_hram && !cpu_write_enable;

        if (reset) begin
            mem_address      = cpu_address;
            mem_write_enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= 8'h00;
            src_hi_reg     <= 8'h00;
            dma_byte_reg   <= 8'h00;
            blocked_reg    <= 1'b0;
            rd_granted_reg <= 1'b0;
            dma_active_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            src_hi_reg     <= src_hi_next;
            blocked_reg    <= blocked_next;
            rd_granted_reg <= rd_granted_next;
            dma_active_reg <= (state_next != IDLE);
            if (rd_granted_reg) begin
                dma_byte_reg <= mem_data_in;
            end
        end
    end

    assign cpu_data_in = blocked_reg ? 8'hFF : mem_data_in;
    assign dma_active  = dma_active_reg;

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Sits between the CPU bus and the single-port system memory. It shares that one bus between CPU accesses and a Game Boy style OAM DMA engine. A CPU write to the DMA register starts a 160-byte copy from `{src_hi, 8'h00}` to OAM, sequenced as alternating read and write bus cycles. While the copy runs, the CPU may only reach HRAM: other reads return `8'hFF` and other writes are dropped.

## Interface
Parameters:
- `DMA_REG_ADDR`, `16'hFF46`: DMA start register address.
- `DMA_LENGTH`, `160`: bytes per transfer.
- `OAM_BASE`, `16'hFE00`: destination base address.
- `HRAM_LO` / `HRAM_HI`, `16'hFF80` / `16'hFFFE`: inclusive address range the CPU may still access during DMA.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cpu_address` in 16: CPU bus address.
- `cpu_data_out` in 8: CPU write data.
- `cpu_write_enable` in 1: 1 means write, 0 means read.
- `cpu_data_in` out 8: read data returned to the CPU.
- `mem_address` out 16: memory address.
- `mem_data_out` out 8: memory write data.
- `mem_write_enable` out 1: memory write strobe.
- `mem_data_in` in 8: memory read data, registered, valid 1 cycle after its address.
- `dma_active` out 1: high while a transfer is in progress.

## Operation
- **States.**
  - IDLE: the CPU owns the bus. `mem_*` equal `cpu_*` combinationally.
  - DMA_READ: DMA drives `mem_address = src + idx`, `mem_write_enable = 0`.
  - DMA_WRITE: DMA drives `mem_address = OAM_BASE + idx`, `mem_write_enable = 1`, data = fetched byte.
- **Start.** In IDLE, a CPU write to `DMA_REG_ADDR`:
  - passes through to memory (readback works);
  - latches `src_hi = cpu_data_out`, `idx = 0`;
  - moves the state to DMA_READ.
- **Source remap.** If `src_hi >= 8'hE0`, the effective high byte is `src_hi - 8'h20` (echo RAM).
- **Transitions.**
  - DMA_READ → DMA_WRITE.
  - DMA_WRITE → DMA_READ with `idx + 1`.
  - After the write with `idx = DMA_LENGTH-1`, return to IDLE.
- **Bus sharing during DMA.**
  - CPU access with `HRAM_LO <= cpu_address <= HRAM_HI`: the CPU owns the bus that cycle and `mem_*` pass the CPU signals. The DMA state and `idx` hold (the DMA is stalled).
  - Any other CPU access: reads return `8'hFF` in the data cycle, writes are never presented to memory. This includes writes to `DMA_REG_ADDR`, so there is no restart during DMA.
- **Fetched byte.**
  - The cycle after a granted DMA_READ, `dma_byte <= mem_data_in`.
  - A DMA_WRITE in the cycle immediately after its granted read uses `mem_data_in` directly (bypass).
  - A DMA_WRITE delayed by an HRAM stall uses `dma_byte`.
- **CPU read data.** The 1-bit register `blocked_q` records that the previous cycle held a blocked CPU read. `cpu_data_in = blocked_q ? 8'hFF : mem_data_in`.

## Timing
- **Reset.** State IDLE, `idx = 0`, `src_hi = 0`, `dma_byte = 0`, `blocked_q = 0`, `dma_active = 0`. While reset is high, `mem_write_enable = 0` and `mem_address = cpu_address`.
- **Reset mid-transfer.** Aborts immediately. No further OAM writes; bytes already written stay written.
- **Start latency.** DMA_REG write at cycle N, first DMA_READ at N+1. `dma_active` is registered: high from N+1 until the last DMA_WRITE cycle inclusive.
- **Duration.** Without stalls, the last write is at N+320 and `dma_active` is 0 at N+321. Each HRAM access adds exactly 1 cycle.
- **CPU read latency.** 1 cycle, for both HRAM and blocked reads, matching the memory's registered read.
- **Simultaneous events.** A CPU non-HRAM write in the same cycle as DMA_WRITE is dropped; DMA proceeds.
- **Boundary.** `idx` is 8 bits. Source address = `{src_eff, idx}`, no carry into the high byte.

## Structure
- Package `gb_bus_pkg`:
  - bus constants `DMA_REG_ADDR`, `OAM_BASE`, `HRAM_LO`, `HRAM_HI`, `DMA_LENGTH`;
  - state enum `dma_state_t` {IDLE, DMA_READ, DMA_WRITE};
  - function `is_hram(addr)`.
- Single module, no sub-modules. Bus muxing is combinational; state, `idx`, `src_hi`, `dma_byte`, `blocked_q` are registered.

## Test plan
- **Basic copy.** Memory `C000..C09F = i ^ 8'h5A`, CPU writes `8'hC0` to `FF46` → `FE00+i == i ^ 8'h5A` for all 160 bytes. `dma_active` high exactly 320 cycles. `FF46` reads back `8'hC0`.
- **Blocked access.** CPU reads `0x1000` (holds `8'h88`) during DMA → `cpu_data_in == 8'hFF` next cycle. CPU writes `8'h33` to `0x1000` during DMA → memory still `8'h88`.
- **HRAM during DMA.** CPU writes `8'h66` to `FF80`, then reads it, during DMA:
  - `memory[FF80] == 8'h66` and the read returns `8'h66`;
  - `dma_active` lasts 322 cycles;
  - all OAM bytes are correct, including a stall that lands between a read and its write (exercises `dma_byte`).
- **Echo remap.** Write `8'hE1` to `FF46` → OAM receives `C100..C19F`.
- **Reset mid-transfer.** Assert reset after 100 cycles → `dma_active = 0` the next cycle. `FE32..FE9F` unchanged; `FE00..FE31` copied.
- **Back-to-back.** CPU writes `FF46` again during DMA (ignored), then again after completion → a second full transfer starts from the new source.
